mte_stream: RTL and testbench

Streaming, parametrised MAC-then-encrypt engine that processes whole frames over valid/ready handshakes.
- Encrypt mode: accepts plaintext bytes up to an EOF symbol, emits ciphertext, then appends one encrypted MAC word.
- Decrypt mode: buffers the decrypted frame, checks the trailing MAC, then releases either the plaintext or an all-zero frame.
- Sits between the host byte interface and the link layer, replacing the single-word combinational datapath with frame-level operation and MAC gating.

---
 rtl/mte_stream_if.sv | 23 ++
 rtl/mte_stream.sv | 148 ++++++++++++++
 tb/tb_mte_stream.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mte_stream_if.sv
// Byte-stream handshake bundle for mte_stream: input word channel and output word channel,
// each with valid/ready; out_last marks the final word of an output frame.
interface mte_stream_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mte_stream.sv
// Frame-level MAC-then-encrypt engine: encrypts a frame and appends an encrypted MAC word,
// or decrypts a buffered frame and releases it only if the trailing MAC matches.
module mte_stream #(
  parameter int           W     = 8,
  parameter int           DEPTH = 32,
  parameter logic [W-1:0] EOF   = 'h03
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] key,
  input  logic         sel,
  mte_stream_if.slave  bus,
  output logic         mac_ok,
  output logic         mac_err,
  output logic         busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, ENC_DATA, ENC_MAC, DEC_DATA, DEC_MAC, DEC_DRAIN} state_t;

  state_t        state_q;
  logic [W-1:0]  k_q, mac_q, out_data_q;
  logic [CW-1:0] cnt_q, rd_q;
  logic          pass_q, out_valid_q, out_last_q, mac_ok_q, mac_err_q;
  logic [W-1:0]  buf_q [DEPTH];

  function automatic logic [W-1:0] rotl1(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]};
  endfunction

  function automatic logic [W-1:0] rotr1(input logic [W-1:0] x);
    return {x[0], x[W-1:1]};
  endfunction

  function automatic logic [W-1:0] enc_w(input logic [W-1:0] d, input logic [W-1:0] k);
    return rotl1(d ^ k);
  endfunction

  function automatic logic [W-1:0] dec_w(input logic [W-1:0] c, input logic [W-1:0] k);
    return rotr1(c) ^ k;
  endfunction

  logic          out_free, in_ready_c, hs, data_st, cur_enc, last_word, mac_match;
  logic [W-1:0]  cur_k, p_word, mac_d;
  logic [CW-1:0] cnt_base;

  // In IDLE the live key/sel apply, so the frame's first word is processed in the same cycle it is latched.
  always_comb begin
    out_free = !out_valid_q || bus.out_ready;
    case (state_q)
      IDLE, ENC_DATA:    in_ready_c = out_free;
      DEC_DATA, DEC_MAC: in_ready_c = 1'b1;
      default:           in_ready_c = 1'b0;
    endcase
    hs        = bus.in_valid && in_ready_c;
    data_st   = state_q inside {IDLE, ENC_DATA, DEC_DATA};
    cur_k     = (state_q == IDLE) ? key : k_q;
    cur_enc   = (state_q == IDLE) ? sel : (state_q == ENC_DATA);
    p_word    = cur_enc ? bus.in_data : dec_w(bus.in_data, cur_k);
    mac_d     = rotl1((state_q == IDLE) ? cur_k : mac_q) ^ p_word;
    cnt_base  = (state_q == IDLE) ? '0 : cnt_q;
    last_word = (p_word == EOF) || (cnt_base == CW'(DEPTH - 1));
    mac_match = (dec_w(bus.in_data, k_q) == mac_q);
  end

  always_ff @(posedge clock) begin
    if (hs && data_st && !cur_enc) buf_q[cnt_base[AW-1:0]] <= p_word;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      mac_q       <= '0;
      cnt_q       <= '0;
      rd_q        <= '0;
      pass_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      mac_ok_q    <= 1'b0;
      mac_err_q   <= 1'b0;
    end else begin
      mac_ok_q  <= 1'b0;
      mac_err_q <= 1'b0;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      case (state_q)
        IDLE, ENC_DATA, DEC_DATA: begin
          if (hs) begin
            k_q   <= cur_k;
            mac_q <= mac_d;
            cnt_q <= cnt_base + CW'(1);
            if (cur_enc) begin
              out_valid_q <= 1'b1;
              out_data_q  <= enc_w(p_word, cur_k);
              out_last_q  <= 1'b0;
              state_q     <= last_word ? ENC_MAC : ENC_DATA;
            end else begin
              state_q <= last_word ? DEC_MAC : DEC_DATA;
            end
          end
        end
        ENC_MAC: begin
          if (out_valid_q && out_last_q) begin
            if (bus.out_ready) state_q <= IDLE;
          end else if (out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= enc_w(mac_q, k_q);
            out_last_q  <= 1'b1;
          end
        end
        DEC_MAC: begin
          if (bus.in_valid) begin
            pass_q    <= mac_match;
            mac_ok_q  <= mac_match;
            mac_err_q <= !mac_match;
            rd_q      <= '0;
            state_q   <= DEC_DRAIN;
          end
        end
        DEC_DRAIN: begin
          // A failed MAC still drains the full frame length, but as zeros.
          if (out_valid_q && out_last_q) begin
            if (bus.out_ready) state_q <= IDLE;
          end else if (out_free && (rd_q != cnt_q)) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pass_q ? buf_q[rd_q[AW-1:0]] : '0;
            out_last_q  <= (rd_q == cnt_q - CW'(1));
            rd_q        <= rd_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign mac_ok        = mac_ok_q;
  assign mac_err       = mac_err_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_mte_stream.sv
// Directed bench for mte_stream: frame vectors from a table plus hand-written stall,
// forced-close and mid-frame reset sequences.
module tb_mte_stream;
  localparam int W = 8;
  typedef logic [W-1:0] word_t;

  typedef struct {
    logic  s;
    word_t k;
    int    nin;
    word_t din [8];
    int    nout;
    word_t dout [8];
    int    mac;
  } vec_t;

  typedef struct {
    word_t got [8];
    int    n;
    int    okc;
    int    errc;
    int    lastpos;
    int    stall_bad;
    int    first_v;
    int    pulse;
  } mon_t;

  logic  clock = 1'b0;
  logic  rst_n = 1'b0;
  word_t key0, key1;
  logic  sel0, sel1;
  logic  ok0, err0, busy0, ok1, err1, busy1;

  always #5 clock = ~clock;

  mte_stream_if #(.W(W)) if0 ();
  mte_stream_if #(.W(W)) if1 ();

  mte_stream #(.W(W), .DEPTH(32), .EOF(8'h03)) u0 (
    .clock(clock), .rst_n(rst_n), .key(key0), .sel(sel0), .bus(if0.slave),
    .mac_ok(ok0), .mac_err(err0), .busy(busy0)
  );

  mte_stream #(.W(W), .DEPTH(4), .EOF(8'h03)) u1 (
    .clock(clock), .rst_n(rst_n), .key(key1), .sel(sel1), .bus(if1.slave),
    .mac_ok(ok1), .mac_err(err1), .busy(busy1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(int which, logic v, word_t d);
    if (which == 1) begin if1.in_valid = v; if1.in_data = d; end
    else begin if0.in_valid = v; if0.in_data = d; end
  endtask

  task automatic set_ks(int which, word_t k, logic s);
    if (which == 1) begin key1 = k; sel1 = s; end
    else begin key0 = k; sel0 = s; end
  endtask

  task automatic set_ordy(int which, logic r);
    if (which == 1) if1.out_ready = r;
    else if0.out_ready = r;
  endtask

  task automatic drive(int which, logic s, word_t k, word_t w [8], int nw, bit kchg, output bit timeout);
    int i = 0;
    set_ks(which, k, s);
    set_in(which, 1'b1, w[0]);
    for (int cyc = 0; cyc < 200 && i < nw; cyc++) begin
      logic hs;
      @(negedge clock);
      hs = (which == 1) ? if1.in_ready : if0.in_ready;
      @(posedge clock); #1;
      if (hs) begin
        i++;
        if (kchg) set_ks(which, ~k, ~s);
        if (i < nw) set_in(which, 1'b1, w[i]);
        else set_in(which, 1'b0, '0);
      end
    end
    set_in(which, 1'b0, '0);
    timeout = (i < nw);
  endtask

  task automatic monitor(int which, bit rnd, output mon_t m);
    bit    pv = 1'b0;
    bit    done = 1'b0;
    word_t pd = '0;
    logic  pl = 1'b0;
    logic  r, v, l, ok, er;
    word_t d;
    m.n = 0; m.okc = 0; m.errc = 0; m.lastpos = -1; m.stall_bad = 0; m.first_v = -1; m.pulse = -1;
    for (int i = 0; i < 8; i++) m.got[i] = '0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      set_ordy(which, r);
      @(negedge clock);
      v  = (which == 1) ? if1.out_valid : if0.out_valid;
      d  = (which == 1) ? if1.out_data  : if0.out_data;
      l  = (which == 1) ? if1.out_last  : if0.out_last;
      ok = (which == 1) ? ok1  : ok0;
      er = (which == 1) ? err1 : err0;
      if (ok) m.okc++;
      if (er) m.errc++;
      if ((ok || er) && m.pulse < 0) m.pulse = cyc;
      if (v && m.first_v < 0) m.first_v = cyc;
      if (pv && (!v || d !== pd || l !== pl)) m.stall_bad++;
      pv = v && !r; pd = d; pl = l;
      if (v && r) begin
        if (m.n < 8) m.got[m.n] = d;
        if (l) begin m.lastpos = m.n; done = 1'b1; end
        m.n++;
      end
      @(posedge clock); #1;
    end
    set_ordy(which, 1'b1);
  endtask

  task automatic run_frame(int which, vec_t v, bit kchg, bit rnd, output mon_t m);
    bit to;
    @(posedge clock); #1;
    fork
      drive(which, v.s, v.k, v.din, v.nin, kchg, to);
      monitor(which, rnd, m);
    join
    check("drive_timeout", 32'(to), 32'd0);
  endtask

  task automatic check_frame(string tag, vec_t v, mon_t m, bit chk_lat);
    check({tag, "_count"}, m.n, v.nout);
    for (int i = 0; i < v.nout; i++)
      check($sformatf("%s_word%0d", tag, i), 32'(m.got[i]), 32'(v.dout[i]));
    check({tag, "_lastpos"}, m.lastpos, v.nout - 1);
    check({tag, "_mac_ok"}, m.okc, (v.mac == 1) ? 1 : 0);
    check({tag, "_mac_err"}, m.errc, (v.mac == 2) ? 1 : 0);
    check({tag, "_stall_stable"}, m.stall_bad, 0);
    if (chk_lat) begin
      check({tag, "_first_valid_cyc"}, m.first_v, v.s ? 1 : v.nin + 1);
      if (!v.s) check({tag, "_pulse_cyc"}, m.pulse, v.nin);
    end
  endtask

  vec_t  vecs [3];
  vec_t  v5;
  mon_t  m;
  word_t s5_in [4];

  initial begin
    for (int i = 0; i < 3; i++) begin
      vecs[i].s = 1'b0; vecs[i].k = '0; vecs[i].nin = 0; vecs[i].nout = 0; vecs[i].mac = 0;
      for (int j = 0; j < 8; j++) begin vecs[i].din[j] = '0; vecs[i].dout[j] = '0; end
    end
    vecs[0].s = 1'b1; vecs[0].k = 8'h5A; vecs[0].nin = 2; vecs[0].nout = 3; vecs[0].mac = 0;
    vecs[0].din[0] = 8'h41; vecs[0].din[1] = 8'h03;
    vecs[0].dout[0] = 8'h36; vecs[0].dout[1] = 8'hB2; vecs[0].dout[2] = 8'h65;
    vecs[1].s = 1'b0; vecs[1].k = 8'h5A; vecs[1].nin = 3; vecs[1].nout = 2; vecs[1].mac = 1;
    vecs[1].din[0] = 8'h36; vecs[1].din[1] = 8'hB2; vecs[1].din[2] = 8'h65;
    vecs[1].dout[0] = 8'h41; vecs[1].dout[1] = 8'h03;
    vecs[2].s = 1'b0; vecs[2].k = 8'h5A; vecs[2].nin = 3; vecs[2].nout = 2; vecs[2].mac = 2;
    vecs[2].din[0] = 8'h36; vecs[2].din[1] = 8'hB2; vecs[2].din[2] = 8'h64;
    vecs[2].dout[0] = 8'h00; vecs[2].dout[1] = 8'h00;

    v5.s = 1'b1; v5.k = 8'h00; v5.nin = 4; v5.nout = 5; v5.mac = 0;
    for (int j = 0; j < 8; j++) begin v5.din[j] = '0; v5.dout[j] = '0; end
    s5_in = '{8'h10, 8'h20, 8'h30, 8'h40};
    v5.dout[0] = 8'h20; v5.dout[1] = 8'h40; v5.dout[2] = 8'h60; v5.dout[3] = 8'h80; v5.dout[4] = 8'h40;

    key0 = '0; key1 = '0; sel0 = 1'b0; sel1 = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(if0.out_valid), 32'd0);
    check("rst_out_data", 32'(if0.out_data), 32'd0);
    check("rst_out_last", 32'(if0.out_last), 32'd0);
    check("rst_mac_ok", 32'(ok0), 32'd0);
    check("rst_mac_err", 32'(err0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_in_ready", 32'(if0.in_ready), 32'd1);
    @(negedge clock);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run_frame(0, vecs[i], 1'b0, 1'b0, m);
      check_frame($sformatf("vec%0d", i), vecs[i], m, 1'b1);
      check($sformatf("vec%0d_busy_after", i), 32'(busy0), 32'd0);
      repeat (2) @(posedge clock);
    end

    // Random backpressure with key/sel toggling after the first word.
    run_frame(0, vecs[0], 1'b1, 1'b1, m);
    check_frame("stall", vecs[0], m, 1'b0);
    check("stall_busy_after", 32'(busy0), 32'd0);

    // DEPTH=4 forced close; in_ready must drop while the MAC word is pending.
    set_ks(1, 8'h00, 1'b1);
    @(posedge clock); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          set_in(1, 1'b1, s5_in[i]);
          @(negedge clock);
          check($sformatf("force_in_ready%0d", i), 32'(if1.in_ready), 32'd1);
          @(posedge clock); #1;
        end
        set_in(1, 1'b1, 8'h55);
        @(negedge clock);
        check("force_in_ready_mac", 32'(if1.in_ready), 32'd0);
        @(posedge clock); #1;
        set_in(1, 1'b0, '0);
      end
      monitor(1, 1'b0, m);
    join
    check_frame("force", v5, m, 1'b1);
    @(posedge clock); #1;
    check("force_busy_after", 32'(busy1), 32'd0);

    // Reset while the decrypt frame is partly received.
    set_ks(0, 8'h5A, 1'b0);
    set_in(0, 1'b1, 8'h36);
    @(posedge clock); #1;
    set_in(0, 1'b0, '0);
    check("midrst_busy_before", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(if0.out_valid), 32'd0);
    check("midrst_out_last", 32'(if0.out_last), 32'd0);
    check("midrst_mac_ok", 32'(ok0), 32'd0);
    check("midrst_mac_err", 32'(err0), 32'd0);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_in_ready", 32'(if0.in_ready), 32'd1);
    @(negedge clock);
    rst_n = 1'b1;
    run_frame(0, vecs[1], 1'b0, 1'b0, m);
    check_frame("postrst", vecs[1], m, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
